dst_data_unpack: RTL and testbench

- Sits directly downstream of the source data buffer.
- Accepts full 512-bit words from the buffer and serialises each word into destination-port beats of 8b, 32b or 512b, selected by mode.
- Uses a valid/ready handshake toward the destination write port.
- Holds one word, and can take a new word back-to-back with the last beat of the previous word.

---
 rtl/dst_data_unpack.sv | 78 +++++++
 tb/tb_dst_data_unpack.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dst_data_unpack.sv
// dst_data_unpack: serialises 512-bit buffer words into 8b/32b/512b destination beats
module dst_data_unpack #(
  parameter int          DATA_W       = 512,
  parameter logic [3:0]  DEFAULT_MODE = 4'd2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_vld,
  input  logic [3:0]        mode,
  input  logic              din_vld,
  input  logic [DATA_W-1:0] din,
  output logic              din_rdy,
  output logic              dout_vld,
  output logic [DATA_W-1:0] dout,
  output logic              dout_last,
  input  logic              dout_rdy,
  output logic              busy
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t            state_q, state_d;
  logic [3:0]        cfg_mode_q, cfg_mode_d;
  logic [3:0]        word_mode_q, word_mode_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [5:0]        beat_cnt_q, beat_cnt_d;
  logic [5:0]        last_idx;
  logic [DATA_W-1:0] beat;
  logic              send;
  logic              accept;
  assign send   = state_q == SEND;
  assign accept = din_vld & din_rdy;
  // Select the current beat and the index of the final beat from the held word's mode
  always_comb begin
    last_idx = word_mode_q == 4'd0 ? 6'd63 : word_mode_q == 4'd1 ? 6'd15 : 6'd0;
    beat = word_mode_q == 4'd0 ? {{(DATA_W-8){1'b0}}, word_q[{beat_cnt_q, 3'b000} +: 8]} :
           word_mode_q == 4'd1 ? {{(DATA_W-32){1'b0}}, word_q[{beat_cnt_q[3:0], 5'b00000} +: 32]} :
           word_q;
  end
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // Next state: leave SEND only when the last beat goes out with no word waiting
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && din_vld) state_d = SEND;
    if (send && dout_rdy && dout_last && !din_vld) state_d = IDLE;
  end
  // Outputs; din_rdy in SEND is combinational so a new word lands with the last beat
  always_comb begin
    dout_vld  = send;
    busy      = send;
    dout_last = send && beat_cnt_q == last_idx;
    dout      = send ? beat : '0;
    din_rdy   = !send || (dout_rdy && dout_last);
  end
  // Datapath next state: mode shadow, word capture and beat counter
  always_comb begin
    cfg_mode_d  = (mode_vld && mode <= 4'd2) ? mode : cfg_mode_q;
    word_d      = accept ? din : word_q;
    word_mode_d = accept ? cfg_mode_q : word_mode_q;
    beat_cnt_d  = accept ? 6'd0 : (dout_vld && dout_rdy && !dout_last) ? beat_cnt_q + 6'd1 : beat_cnt_q;
  end
  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_mode_q  <= DEFAULT_MODE;
      word_mode_q <= 4'd0;
      word_q      <= '0;
      beat_cnt_q  <= 6'd0;
    end else begin
      cfg_mode_q  <= cfg_mode_d;
      word_mode_q <= word_mode_d;
      word_q      <= word_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_dst_data_unpack.sv
// tb_dst_data_unpack: directed tests for dst_data_unpack
module tb_dst_data_unpack;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode_vld;
  logic [3:0]   mode;
  logic         din_vld;
  logic [511:0] din;
  logic         din_rdy;
  logic         dout_vld;
  logic [511:0] dout;
  logic         dout_last;
  logic         dout_rdy;
  logic         busy;
  int checks = 0;
  int errors = 0;

  dst_data_unpack dut (
    .clk(clk), .rst_n(rst_n), .mode_vld(mode_vld), .mode(mode),
    .din_vld(din_vld), .din(din), .din_rdy(din_rdy),
    .dout_vld(dout_vld), .dout(dout), .dout_last(dout_last),
    .dout_rdy(dout_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] w32(input logic [31:0] base);
    logic [511:0] w;
    for (int j = 0; j < 16; j++) w[j*32 +: 32] = base + 32'(j);
    return w;
  endfunction

  function automatic logic [511:0] w8(input logic [7:0] mul, input logic [7:0] add);
    logic [511:0] w;
    for (int j = 0; j < 64; j++) w[j*8 +: 8] = 8'(mul * 8'(j) + add);
    return w;
  endfunction

  task automatic set_mode(input logic [3:0] m);
    @(negedge clk);
    mode_vld = 1'b1;
    mode = m;
    din_vld = 1'b0;
    @(negedge clk);
    mode_vld = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mode_vld = 1'b0; mode = 4'd0; din_vld = 1'b0; din = '0; dout_rdy = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (dout_vld !== 1'b0 || busy !== 1'b0 || dout_last !== 1'b0 || dout !== '0 || din_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset: vld=%b busy=%b last=%b rdy=%b dout=%h, want 0 0 0 1 0", dout_vld, busy, dout_last, din_rdy, dout);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_512;
    logic [511:0] w;
    for (int j = 0; j < 16; j++) w[j*32 +: 32] = 32'hA5A5_0000 + 32'(j);
    @(negedge clk);
    din_vld = 1'b1; din = w; dout_rdy = 1'b1;
    #1;
    checks++;
    if (din_rdy !== 1'b1 || dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL w512_idle: rdy=%b vld=%b, want 1 0", din_rdy, dout_vld);
    end
    @(negedge clk);
    din_vld = 1'b0;
    #1;
    checks++;
    if (dout_vld !== 1'b1 || dout !== w || dout_last !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL w512_beat: vld=%b last=%b busy=%b dout=%h want %h", dout_vld, dout_last, busy, dout, w);
    end
    @(negedge clk);
    #1;
    checks++;
    if (dout_vld !== 1'b0 || din_rdy !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL w512_done: vld=%b rdy=%b busy=%b, want 0 1 0", dout_vld, din_rdy, busy);
    end
  endtask

  task automatic test_32;
    logic [511:0] e;
    set_mode(4'd1);
    din_vld = 1'b1; din = w32(32'h0); dout_rdy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      din_vld = 1'b0;
      #1;
      e = '0; e[31:0] = 32'(k);
      checks++;
      if (dout_vld !== 1'b1 || dout !== e || dout_last !== (k == 15)) begin
        errors++;
        $display("FAIL w32 beat %0d: vld=%b last=%b dout=%h want %h", k, dout_vld, dout_last, dout, e);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL w32_done: vld=%b want 0", dout_vld);
    end
  endtask

  task automatic test_back_to_back;
    logic [511:0] e;
    set_mode(4'd1);
    din_vld = 1'b1; din = w32(32'h100); dout_rdy = 1'b1;
    for (int b = 0; b < 32; b++) begin
      @(negedge clk);
      din = w32(32'h200);
      din_vld = b < 16;
      #1;
      e = '0; e[31:0] = b < 16 ? 32'h100 + 32'(b) : 32'h200 + 32'(b - 16);
      checks++;
      if (dout_vld !== 1'b1 || dout !== e || dout_last !== (b % 16 == 15) || din_rdy !== (b % 16 == 15)) begin
        errors++;
        $display("FAIL b2b beat %0d: vld=%b last=%b rdy=%b dout=%h want %h", b, dout_vld, dout_last, din_rdy, dout, e);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: vld=%b want 0", dout_vld);
    end
  endtask

  task automatic test_8_backpressure;
    logic [511:0] w;
    logic [511:0] e;
    int k = 0;
    w = w8(8'h11, 8'h11);
    set_mode(4'd0);
    din_vld = 1'b1; din = w; dout_rdy = 1'b0;
    @(negedge clk);
    din_vld = 1'b0;
    for (int c = 0; c < 200 && k < 64; c++) begin
      dout_rdy = c[0];
      #1;
      e = '0; e[7:0] = w[k*8 +: 8];
      checks++;
      if (dout_vld !== 1'b1 || dout !== e || dout_last !== (k == 63)) begin
        errors++;
        $display("FAIL w8bp beat %0d: vld=%b last=%b dout=%h want %h", k, dout_vld, dout_last, dout, e);
      end
      if (dout_rdy) k++;
      @(negedge clk);
    end
    checks++;
    if (k != 64 || dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL w8bp_count: beats=%0d vld=%b, want 64 0", k, dout_vld);
    end
    dout_rdy = 1'b1;
  endtask

  task automatic test_mode_change;
    logic [511:0] w;
    logic [511:0] e;
    set_mode(4'd1);
    din_vld = 1'b1; din = w32(32'h300); dout_rdy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      din_vld = 1'b0;
      mode_vld = (k == 5 || k == 8);
      mode = k == 5 ? 4'd0 : 4'd7;
      #1;
      e = '0; e[31:0] = 32'h300 + 32'(k);
      checks++;
      if (dout_vld !== 1'b1 || dout !== e || dout_last !== (k == 15)) begin
        errors++;
        $display("FAIL modechg w32 beat %0d: vld=%b last=%b dout=%h want %h", k, dout_vld, dout_last, dout, e);
      end
    end
    w = w8(8'h03, 8'h01);
    @(negedge clk);
    mode_vld = 1'b0; din_vld = 1'b1; din = w;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      din_vld = 1'b0;
      #1;
      e = '0; e[7:0] = 8'(8'h03 * 8'(k) + 8'h01);
      checks++;
      if (dout_vld !== 1'b1 || dout !== e || dout_last !== (k == 63)) begin
        errors++;
        $display("FAIL modechg w8 beat %0d: vld=%b last=%b dout=%h want %h", k, dout_vld, dout_last, dout, e);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL modechg_done: vld=%b want 0", dout_vld);
    end
  endtask

  task automatic test_reset_mid;
    logic [511:0] e;
    logic [511:0] w;
    set_mode(4'd1);
    din_vld = 1'b1; din = w32(32'h400); dout_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      din_vld = 1'b0;
      #1;
      e = '0; e[31:0] = 32'h400 + 32'(k);
      checks++;
      if (dout_vld !== 1'b1 || dout !== e) begin
        errors++;
        $display("FAIL rstmid beat %0d: vld=%b dout=%h want %h", k, dout_vld, dout, e);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout_vld !== 1'b0 || busy !== 1'b0 || din_rdy !== 1'b1 || dout !== '0) begin
      errors++;
      $display("FAIL rstmid_async: vld=%b busy=%b rdy=%b dout=%h, want 0 0 1 0", dout_vld, busy, din_rdy, dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (dout_vld !== 1'b0 || busy !== 1'b0 || din_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_release: vld=%b busy=%b rdy=%b, want 0 0 1", dout_vld, busy, din_rdy);
    end
    w = w32(32'h5000_0000);
    @(negedge clk);
    din_vld = 1'b1; din = w;
    @(negedge clk);
    din_vld = 1'b0;
    #1;
    checks++;
    if (dout_vld !== 1'b1 || dout !== w || dout_last !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_next512: vld=%b last=%b dout=%h want %h", dout_vld, dout_last, dout, w);
    end
    @(negedge clk);
    #1;
    checks++;
    if (dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_done: vld=%b want 0", dout_vld);
    end
  endtask

  initial begin
    test_reset;
    test_512;
    test_32;
    test_back_to_back;
    test_8_backpressure;
    test_mode_change;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
